// File: rtl/onecount_arbiter.sv
// Round-robin scheduler sharing one serial ones-counting engine among NREQ
// bit-stream requesters; reports per-frame ones total, hit flag and abort.
module onecount_arbiter #(
  parameter int NREQ = 4,
  parameter int MOD  = 4,
  parameter int CW   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         bit_in,
  input  logic [NREQ-1:0]         bit_vld,
  input  logic [NREQ-1:0]         bit_last,
  output logic [NREQ-1:0]         bit_rdy,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic [CW-1:0]           done_ones,
  output logic                    done_hit,
  output logic                    done_abort
);

  localparam int IDW = $clog2(NREQ);
  localparam int MW  = $clog2(MOD);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_REPORT} state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_bit_rdy;
  logic            r_busy;
  logic            r_done;
  logic [IDW-1:0]  r_done_id;
  logic [CW-1:0]   r_done_ones;
  logic            r_done_hit;
  logic            r_done_abort;
  logic [IDW-1:0]  r_id;
  logic [IDW-1:0]  r_last_id;
  logic [CW-1:0]   r_ones;
  logic [MW-1:0]   r_mod;

  logic [IDW-1:0]  w_cand [NREQ];
  logic [NREQ-1:0] w_sel;
  logic [NREQ-1:0] w_take;
  logic [IDW-1:0]  w_win_id;
  logic            w_any;
  logic            w_acc;
  logic            w_bit;
  logic            w_last;
  logic            w_req;
  logic [CW-1:0]   w_ones_inc;
  logic [MW-1:0]   w_mod_inc;
  logic            w_hit_acc;

  // Candidate gi is the (gi+1)-th requester after the last one served.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_scan
      assign w_cand[gi] = IDW'((int'(r_last_id) + gi + 1) % NREQ);
      assign w_sel[gi]  = req[w_cand[gi]];
      if (gi == 0) begin : g_first
        assign w_take[gi] = w_sel[gi];
      end else begin : g_rest
        assign w_take[gi] = w_sel[gi] & ~(|w_sel[gi-1:0]);
      end
    end
  endgenerate

  always_comb begin
    w_win_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_take[k]) w_win_id = w_win_id | w_cand[k];
    end
  end

  assign w_any  = |req;
  assign w_acc  = bit_vld[r_id] & r_bit_rdy[r_id];
  assign w_bit  = bit_in[r_id];
  assign w_last = bit_last[r_id];
  assign w_req  = req[r_id];

  // Ones total saturates; the modulo counter keeps counting exactly.
  always_comb begin
    w_ones_inc = r_ones;
    w_mod_inc  = r_mod;
    if (w_bit) begin
      if (r_ones != '1) w_ones_inc = r_ones + 1'b1;
      w_mod_inc = (r_mod == MW'(MOD - 1)) ? '0 : r_mod + 1'b1;
    end
  end

  assign w_hit_acc = (w_mod_inc == '0) && (w_ones_inc != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_gnt        <= '0;
      r_bit_rdy    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_done_id    <= '0;
      r_done_ones  <= '0;
      r_done_hit   <= 1'b0;
      r_done_abort <= 1'b0;
      r_id         <= '0;
      r_last_id    <= IDW'(NREQ - 1);
      r_ones       <= '0;
      r_mod        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_any) begin
            r_id      <= w_win_id;
            r_gnt     <= NREQ'(1) << w_win_id;
            r_bit_rdy <= NREQ'(1) << w_win_id;
            r_ones    <= '0;
            r_mod     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_acc) begin
            r_ones <= w_ones_inc;
            r_mod  <= w_mod_inc;
            if (w_last) begin
              r_gnt        <= '0;
              r_bit_rdy    <= '0;
              r_done       <= 1'b1;
              r_done_id    <= r_id;
              r_done_ones  <= w_ones_inc;
              r_done_hit   <= w_hit_acc;
              r_done_abort <= 1'b0;
              r_state      <= S_REPORT;
            end
          end else if (!w_req) begin
            r_gnt        <= '0;
            r_bit_rdy    <= '0;
            r_done       <= 1'b1;
            r_done_id    <= r_id;
            r_done_ones  <= r_ones;
            r_done_hit   <= 1'b0;
            r_done_abort <= 1'b1;
            r_state      <= S_REPORT;
          end
        end
        S_REPORT: begin
          r_done    <= 1'b0;
          r_busy    <= 1'b0;
          r_last_id <= r_id;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign bit_rdy    = r_bit_rdy;
  assign busy       = r_busy;
  assign done       = r_done;
  assign done_id    = r_done_id;
  assign done_ones  = r_done_ones;
  assign done_hit   = r_done_hit;
  assign done_abort = r_done_abort;

endmodule

// File: tb/tb_onecount_arbiter.sv
// Directed bench for onecount_arbiter: frames are queued as expected results
// when driven and matched against each done pulse; a CW=3 instance covers saturation.
module tb_onecount_arbiter;

  localparam int NREQ = 4;
  localparam int MOD  = 4;
  localparam int CW   = 8;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [NREQ-1:0] req, bit_in, bit_vld, bit_last;
  logic [NREQ-1:0] bit_rdy, gnt;
  logic            busy, done, done_hit, done_abort;
  logic [IDW-1:0]  done_id;
  logic [CW-1:0]   done_ones;

  logic [NREQ-1:0] s_req, s_bit_in, s_bit_vld, s_bit_last;
  logic [NREQ-1:0] s_bit_rdy, s_gnt;
  logic            s_busy, s_done, s_done_hit, s_done_abort;
  logic [IDW-1:0]  s_done_id;
  logic [2:0]      s_done_ones;

  onecount_arbiter #(.NREQ(NREQ), .MOD(MOD), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .bit_in(bit_in), .bit_vld(bit_vld),
    .bit_last(bit_last), .bit_rdy(bit_rdy), .gnt(gnt), .busy(busy), .done(done),
    .done_id(done_id), .done_ones(done_ones), .done_hit(done_hit), .done_abort(done_abort)
  );

  onecount_arbiter #(.NREQ(NREQ), .MOD(MOD), .CW(3)) dut_sat (
    .clk(clk), .reset(reset), .req(s_req), .bit_in(s_bit_in), .bit_vld(s_bit_vld),
    .bit_last(s_bit_last), .bit_rdy(s_bit_rdy), .gnt(s_gnt), .busy(s_busy), .done(s_done),
    .done_id(s_done_id), .done_ones(s_done_ones), .done_hit(s_done_hit),
    .done_abort(s_done_abort)
  );

  typedef struct {
    int   id;
    int   ones;
    logic hit;
    logic abort;
  } exp_t;

  exp_t sb[$];
  exp_t m_exp;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int id, input logic [31:0] bits, input int n, input logic abort);
    exp_t e;
    int   c;
    c = 0;
    for (int i = 0; i < n; i++) c += int'(bits[i]);
    e.id    = id;
    e.ones  = (c > (1 << CW) - 1) ? (1 << CW) - 1 : c;
    e.hit   = !abort && (c != 0) && (c % MOD == 0);
    e.abort = abort;
    return e;
  endfunction

  // Result monitor: every done pulse consumes exactly one queued expectation.
  always @(negedge clk) begin
    check("gnt_onehot0", 32'($countones(gnt) <= 1), 1);
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("done_without_frame", {31'b0, done}, 0);
      end else begin
        m_exp = sb.pop_front();
        $display("done id=%0d ones=%0d hit=%0b abort=%0b (exp id=%0d ones=%0d hit=%0b abort=%0b)",
                 done_id, done_ones, done_hit, done_abort, m_exp.id, m_exp.ones, m_exp.hit, m_exp.abort);
        check("done_id", 32'(done_id), m_exp.id);
        check("done_ones", 32'(done_ones), m_exp.ones);
        check("done_hit", {31'b0, done_hit}, {31'b0, m_exp.hit});
        check("done_abort", {31'b0, done_abort}, {31'b0, m_exp.abort});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0; bit_in = '0; bit_vld = '0; bit_last = '0;
    s_req = '0; s_bit_in = '0; s_bit_vld = '0; s_bit_last = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_frame(input logic [IDW-1:0] lane, input logic [31:0] bits, input int n,
                           input logic [NREQ-1:0] req_after, input int exp_wait);
    int cyc;
    cyc = 0;
    sb.push_back(model(int'(lane), bits, n, 1'b0));
    req[lane] = 1'b1;
    while (gnt[lane] !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("grant_wait", cyc, exp_wait);
    check("gnt_lane", 32'(gnt), 32'(NREQ'(1) << lane));
    check("rdy_lane", 32'(bit_rdy), 32'(NREQ'(1) << lane));
    check("busy_stream", {31'b0, busy}, 1);
    for (int i = 0; i < n; i++) begin
      bit_vld[lane]  = 1'b1;
      bit_in[lane]   = bits[i];
      bit_last[lane] = (i == n - 1);
      if (i == n - 1) req = req_after;
      @(negedge clk);
    end
    bit_vld[lane] = 1'b0; bit_in[lane] = 1'b0; bit_last[lane] = 1'b0;
    check("done_after_last", {31'b0, done}, 1);
    check("gnt_report", 32'(gnt), 0);
    check("busy_report", {31'b0, busy}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int cyc;
    reset = 1'b1;
    do_reset();
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_rdy", 32'(bit_rdy), 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_done_id", 32'(done_id), 0);
    check("rst_done_ones", 32'(done_ones), 0);
    check("rst_done_hit", {31'b0, done_hit}, 0);
    check("rst_done_abort", {31'b0, done_abort}, 0);

    // Four ones on lane 0, then 1,0,1,1 and 0,0.
    run_frame(2'd0, 32'b1111, 4, 4'b0000, 1);
    run_frame(2'd0, 32'b1101, 4, 4'b0000, 2);
    run_frame(2'd0, 32'b00, 2, 4'b0000, 2);

    // All requesters held: rotation 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    run_frame(2'd0, 32'b1, 1, 4'b1111, 1);
    run_frame(2'd1, 32'b0, 1, 4'b1111, 2);
    run_frame(2'd2, 32'b1, 1, 4'b1111, 2);
    run_frame(2'd3, 32'b1, 1, 4'b1111, 2);
    run_frame(2'd0, 32'b0, 1, 4'b0000, 2);

    // Saturation with CW=3: twelve ones.
    @(negedge clk);
    s_req[0] = 1'b1;
    cyc = 0;
    while (s_gnt[0] !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("sat_grant_wait", cyc, 1);
    for (int i = 0; i < 12; i++) begin
      s_bit_vld[0] = 1'b1; s_bit_in[0] = 1'b1; s_bit_last[0] = (i == 11);
      if (i == 11) s_req[0] = 1'b0;
      @(negedge clk);
    end
    s_bit_vld[0] = 1'b0; s_bit_in[0] = 1'b0; s_bit_last[0] = 1'b0;
    $display("sat done=%0b ones=%0d hit=%0b abort=%0b", s_done, s_done_ones, s_done_hit, s_done_abort);
    check("sat_done", {31'b0, s_done}, 1);
    check("sat_ones", 32'(s_done_ones), 7);
    check("sat_hit", {31'b0, s_done_hit}, 1);
    check("sat_abort", {31'b0, s_done_abort}, 0);

    // Abort by req drop: lane 2 after two ones, lane 1 after four ones.
    for (int t = 0; t < 2; t++) begin
      logic [IDW-1:0] lane;
      int nb;
      lane = (t == 0) ? 2'd2 : 2'd1;
      nb   = (t == 0) ? 2 : 4;
      @(negedge clk);
      sb.push_back(model(int'(lane), 32'hFFFF_FFFF, nb, 1'b1));
      req[lane] = 1'b1;
      cyc = 0;
      while (gnt[lane] !== 1'b1 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      check("abort_grant_wait", cyc, 1);
      for (int i = 0; i < nb; i++) begin
        bit_vld[lane] = 1'b1; bit_in[lane] = 1'b1;
        @(negedge clk);
      end
      bit_vld[lane] = 1'b0; bit_in[lane] = 1'b0;
      req[lane] = 1'b0;
      @(negedge clk);
      check("abort_done", {31'b0, done}, 1);
      @(negedge clk);
      check("abort_idle_busy", {31'b0, busy}, 0);
      check("abort_idle_gnt", 32'(gnt), 0);
    end

    // Reset in the middle of a lane-3 frame: no done pulse.
    req[3] = 1'b1;
    cyc = 0;
    while (gnt[3] !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_grant_wait", cyc, 1);
    for (int i = 0; i < 2; i++) begin
      bit_vld[3] = 1'b1; bit_in[3] = 1'b1;
      @(negedge clk);
    end
    bit_vld[3] = 1'b0; bit_in[3] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_gnt", 32'(gnt), 0);
    check("rst_mid_busy", {31'b0, busy}, 0);
    check("rst_mid_done", {31'b0, done}, 0);
    check("rst_mid_rdy", 32'(bit_rdy), 0);
    reset = 1'b0;
    req = '0;
    @(negedge clk);
    check("rst_mid_no_done", {31'b0, done}, 0);

    // Noise on non-granted lanes must not touch lane 0's count.
    bit_vld[3:1] = 3'b111; bit_in[3:1] = 3'b111; bit_last[3:1] = 3'b111;
    run_frame(2'd0, 32'b001, 3, 4'b0000, 1);
    bit_vld[3:1] = 3'b000; bit_in[3:1] = 3'b000; bit_last[3:1] = 3'b000;

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
